// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO in front of data_mem with load forwarding.
// Optional in-place store coalescing is enabled by STORE_BUFFER_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_resp_valid,
    output logic [DATA_W-1:0]          ld_resp_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data_to_write,
    input  logic [DATA_W-1:0]          mem_readed_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;
    state_t            state_q;
    logic              mem_write_q, mem_read_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;

    logic              ld_hit, co_hit;
    logic [DATA_W-1:0] ld_hit_data;
    logic [PW-1:0]     co_idx, slot, drain_idx;
    logic [DATA_W-1:0] drain_data;
    logic              push, alloc, coalesce, pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;
    assign ld_ready   = (state_q == IDLE);
    assign flush_done = flush && empty && (state_q == IDLE);

`ifdef STORE_BUFFER_COALESCE_EN
    assign st_ready = (!full || co_hit) && !flush;
`else
    assign st_ready = !full && !flush;
`endif

    assign push     = st_valid && st_ready;
    assign alloc    = push && !co_hit;
    assign coalesce = push && co_hit;
    assign pop      = (state_q == WRITE);

    assign mem_write         = mem_write_q;
    assign mem_read          = mem_read_q;
    assign mem_address       = mem_address_q;
    assign mem_data_to_write = mem_data_q;
    assign ld_resp_valid     = resp_valid_q;
    assign ld_resp_data      = resp_data_q;

    // Search valid entries oldest to youngest; the last match wins.
    always_comb begin
        ld_hit      = 1'b0;
        ld_hit_data = '0;
        co_hit      = 1'b0;
        co_idx      = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (addr_q[slot] == ld_addr) begin
                    ld_hit      = 1'b1;
                    ld_hit_data = data_q[slot];
                end
`ifdef STORE_BUFFER_COALESCE_EN
                // The head being written this cycle is already committed.
                if (addr_q[slot] == st_addr &&
                    !(i == 0 && state_q == WRITE)) begin
                    co_hit = 1'b1;
                    co_idx = slot;
                end
`endif
            end
        end
    end

    // Entry about to be launched to memory; forward a coalescing store into it.
    always_comb begin
        drain_idx  = (state_q == WRITE) ? head_q + PW'(1) : head_q;
        drain_data = data_q[drain_idx];
        if (coalesce && co_idx == drain_idx)
            drain_data = st_data;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                tail_q         <= tail_q + PW'(1);
            end
            if (coalesce)
                data_q[co_idx] <= st_data;
            if (pop)
                head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(alloc) - CW'(pop);
        end
    end

    // Memory-port FSM: one read or write per cycle, all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ld_valid && !ld_hit) begin
                        mem_read_q    <= 1'b1;
                        mem_address_q <= ld_addr;
                        state_q       <= READ;
                    end else begin
                        if (ld_valid) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= ld_hit_data;
                        end
                        if (count_q != '0) begin
                            mem_write_q   <= 1'b1;
                            mem_address_q <= addr_q[head_q];
                            mem_data_q    <= drain_data;
                            state_q       <= WRITE;
                        end
                    end
                end
                READ: begin
                    resp_valid_q  <= 1'b1;
                    resp_data_q   <= mem_readed_data;
                    mem_read_q    <= 1'b0;
                    mem_address_q <= '0;
                    state_q       <= IDLE;
                end
                WRITE: begin
                    if (count_q > CW'(1) && !ld_valid) begin
                        mem_address_q <= addr_q[drain_idx];
                        mem_data_q    <= drain_data;
                    end else begin
                        mem_write_q   <= 1'b0;
                        mem_address_q <= '0;
                        mem_data_q    <= '0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with queue scoreboards for load
// responses and memory writes, checked by a separate monitor.
module tb_store_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0, ld_valid = 1'b0, flush = 1'b0;
    logic [15:0] st_addr = '0, st_data = '0, ld_addr = '0;
    logic        st_ready, ld_ready, ld_resp_valid, flush_done;
    logic        empty, full, mem_write, mem_read;
    logic [15:0] ld_resp_data, mem_address, mem_data_to_write;
    logic [15:0] mem_readed_data;
    logic [2:0]  count;

    logic [15:0] mem [65536];

    typedef struct {
        logic [15:0] data;
        int          due;
    } ld_exp_t;

    ld_exp_t     exp_ld[$];
    logic [31:0] exp_wr[$];

    int checks = 0, failures = 0;
    int cyc = 0, wr_seen = 0;
    bit stop_ld, stream_done, p5_done;

    store_buffer dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .flush(flush), .flush_done(flush_done),
        .empty(empty), .full(full), .count(count),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data_to_write(mem_data_to_write),
        .mem_readed_data(mem_readed_data)
    );

    always #5 clock = ~clock;

    initial begin
        for (int a = 0; a < 65536; a++)
            mem[a] = 16'(a) ^ 16'h5A5A;
    end

    // data_mem model: combinational read, write at the closing edge.
    assign mem_readed_data = mem[mem_address];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_write)
            mem[mem_address] <= mem_data_to_write;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response/write.
    always @(negedge clock) begin
        if (ld_resp_valid) begin
            if (exp_ld.size() == 0) begin
                checks++; failures++;
                $display("FAIL ld_unexpected data=%0h", ld_resp_data);
            end else begin
                ld_exp_t e;
                e = exp_ld.pop_front();
                chk("ld_data", {16'h0, ld_resp_data}, {16'h0, e.data});
                chk("ld_latency", cyc, e.due);
            end
        end
        if (mem_write) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_unexpected addr=%0h", mem_address);
            end else begin
                logic [31:0] w;
                w = exp_wr.pop_front();
                chk("wr_addr", {16'h0, mem_address}, {16'h0, w[31:16]});
                chk("wr_data", {16'h0, mem_data_to_write}, {16'h0, w[15:0]});
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic push_st(input logic [15:0] a, input logic [15:0] d,
                           input bit track);
        int n;
        n = 0;
        st_valid = 1'b1; st_addr = a; st_data = d;
        @(negedge clock);
        while (!st_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (st_ready) begin
            if (track) exp_wr.push_back({a, d});
        end else begin
            checks++; failures++;
            $display("FAIL st_timeout addr=%0h", a);
        end
        sync();
        st_valid = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] d,
                           input bit hit);
        int n;
        n = 0;
        ld_valid = 1'b1; ld_addr = a;
        @(negedge clock);
        while (!ld_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (ld_ready) begin
            exp_ld.push_back('{d, cyc + (hit ? 1 : 2)});
        end else begin
            checks++; failures++;
            $display("FAIL ld_timeout addr=%0h", a);
        end
        sync();
        ld_valid = 1'b0;
    endtask

    // Continuous missing loads to 0x0000 until stop_ld.
    task automatic stream();
        ld_valid = 1'b1; ld_addr = 16'h0000;
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            if (stop_ld) break;
            if (ld_ready) exp_ld.push_back('{16'h5A5A, cyc + 2});
        end
        ld_valid = 1'b0;
        stream_done = 1'b1;
    endtask

    task automatic start_stream();
        stop_ld = 1'b0;
        stream_done = 1'b0;
        fork
            stream();
        join_none
    endtask

    task automatic end_stream();
        stop_ld = 1'b1;
        wait (stream_done);
        sync();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clock);
        while (!(empty && ld_ready && !mem_write && !mem_read) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(nm, {31'h0, empty && ld_ready}, 32'h1);
        sync();
    endtask

    initial begin
        int n, w0;
        logic pw;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_memop", {30'h0, mem_write, mem_read}, 32'h0);
        chk("rst_ready", {30'h0, st_ready, ld_ready}, 32'h3);
        sync();
        reset = 1'b0;
        sync();

        // Single store, then missing load of the same address
        push_st(16'h1111, 16'h0001, 1'b1);
        @(negedge clock);
        chk("t1_wr_c1", {31'h0, mem_write}, 32'h0);
        @(negedge clock);
        chk("t1_wr_c2", {31'h0, mem_write}, 32'h1);
        chk("t1_wr_addr", {16'h0, mem_address}, 32'h1111);
        @(negedge clock);
        chk("t1_wr_c3", {31'h0, mem_write}, 32'h0);
        chk("t1_count", {29'h0, count}, 32'h0);
        sync();
        do_load(16'h1111, 16'h0001, 1'b0);
        @(negedge clock);
        chk("t1_rd", {31'h0, mem_read}, 32'h1);
        chk("t1_rd_addr", {16'h0, mem_address}, 32'h1111);
        @(negedge clock);
        chk("t1_rd_end", {31'h0, mem_read}, 32'h0);
        wait_idle("t1_idle");

        // Streaming loads block the drain; buffer fills
        start_stream();
        w0 = wr_seen;
        for (int i = 0; i < 4; i++)
            push_st(16'h0100 + 16'(i), 16'hC000 + 16'(i), 1'b1);
        @(negedge clock);
        chk("t2_full", {31'h0, full}, 32'h1);
        chk("t2_count", {29'h0, count}, 32'h4);
        chk("t2_st_ready", {31'h0, st_ready}, 32'h0);
        chk("t2_no_wr", wr_seen, w0);
        sync();
        p5_done = 1'b0;
        fork
            begin
                push_st(16'h0104, 16'hC004, 1'b1);
                p5_done = 1'b1;
            end
        join_none
        repeat (6) sync();
        end_stream();
        n = 0;
        @(negedge clock);
        while (!mem_write && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("t2_drain_start", {31'h0, mem_write}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t2_drain_b2b", {31'h0, mem_write}, 32'h1);
        end
        n = 0;
        while (!p5_done && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("t2_p5_done", {31'h0, p5_done}, 32'h1);
        wait_idle("t2_idle");

        // Forwarding from the youngest of two same-address stores
        start_stream();
        push_st(16'h0020, 16'hAAAA, 1'b1);
        push_st(16'h0020, 16'hBBBB, 1'b1);
        end_stream();
        do_load(16'h0020, 16'hBBBB, 1'b1);
        @(negedge clock);
        chk("t3_resp", {31'h0, ld_resp_valid}, 32'h1);
        chk("t3_no_rd", {31'h0, mem_read}, 32'h0);
        wait_idle("t3_idle");
        chk("t3_mem", {16'h0, mem[16'h0020]}, 32'hBBBB);

        // Flush
        push_st(16'h0200, 16'h2000, 1'b1);
        push_st(16'h0201, 16'h2001, 1'b1);
        push_st(16'h0202, 16'h2002, 1'b1);
        flush = 1'b1;
        @(negedge clock);
        chk("t4_st_ready", {31'h0, st_ready}, 32'h0);
        chk("t4_fd_early", {31'h0, flush_done}, 32'h0);
        pw = mem_write;
        n = 0;
        @(negedge clock);
        while (!flush_done && n < 30) begin
            pw = mem_write;
            @(negedge clock);
            n++;
        end
        chk("t4_fd", {31'h0, flush_done}, 32'h1);
        chk("t4_fd_after_wr", {31'h0, pw}, 32'h1);
        chk("t4_fd_count", {29'h0, count}, 32'h0);
        chk("t4_st_ready2", {31'h0, st_ready}, 32'h0);
        sync();
        flush = 1'b0;
        @(negedge clock);
        chk("t4_st_ready3", {31'h0, st_ready}, 32'h1);
        sync();

        // Reset during a write with three entries
        start_stream();
        push_st(16'h0300, 16'h3000, 1'b1);
        push_st(16'h0301, 16'h3001, 1'b1);
        push_st(16'h0302, 16'h3002, 1'b1);
        end_stream();
        n = 0;
        @(negedge clock);
        while (!mem_write && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("t5_wr", {31'h0, mem_write}, 32'h1);
        chk("t5_count", {29'h0, count}, 32'h3);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        exp_wr.delete();
        w0 = wr_seen;
        @(negedge clock);
        chk("t5_memop", {30'h0, mem_write, mem_read}, 32'h0);
        chk("t5_addr", {16'h0, mem_address}, 32'h0);
        chk("t5_count0", {29'h0, count}, 32'h0);
        chk("t5_empty", {31'h0, empty}, 32'h1);
        chk("t5_resp", {31'h0, ld_resp_valid}, 32'h0);
        repeat (8) @(negedge clock);
        chk("t5_no_wr", wr_seen, w0);
        sync();

`ifdef STORE_BUFFER_COALESCE_EN
        // Coalescing store into a full buffer
        start_stream();
        for (int i = 0; i < 4; i++)
            push_st(16'h0400 + 16'(i), 16'hD000 + 16'(i), 1'b1);
        push_st(16'h0402, 16'hEEEE, 1'b0);
        exp_wr[2] = {16'h0402, 16'hEEEE};
        @(negedge clock);
        chk("t6_count", {29'h0, count}, 32'h4);
        sync();
        end_stream();
        wait_idle("t6_idle");
        chk("t6_mem", {16'h0, mem[16'h0402]}, 32'hEEEE);
`endif

        // Everything expected has been observed
        wait_idle("end_idle");
        repeat (4) @(negedge clock);
        chk("end_ld_q", exp_ld.size(), 0);
        chk("end_wr_q", exp_wr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
